// File: rtl/rvfi_commit_serializer.sv
// rvfi_commit_serializer
//
// Verification-side monitor. Captures every RVFI retire bundle that carries
// at least one commit into a bundle FIFO, then replays the committed slots one
// per handshake, in ascending channel order, on a single output stream. Order
// sequencing, PC continuity, commit-after-halt, halt ordering inside a bundle
// and FIFO overflow are checked and reported as sticky error bits.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rvfi_*              NRET-wide retire bundle, channel i in slice i
//   out_valid/out_ready serialized slot handshake
//   out_*               fields of the current head slot (0 while !out_valid)
//   halted              a halt slot has been emitted
//   errcode             sticky error bits:
//                         [0] order, [1] PC, [2] commit-after-halt,
//                         [3] overflow, [4] halt order, [15:5] reserved
//   fifo_level          bundles currently buffered

module rvfi_commit_serializer #(
    parameter int NRET    = 4,
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64,
    parameter int DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRET-1:0]           rvfi_commit,
    input  logic [NRET-1:0]           rvfi_halt,
    input  logic [NRET*ORDER_W-1:0]   rvfi_order,
    input  logic [NRET*32-1:0]        rvfi_inst,
    input  logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]      rvfi_pc_wdata,
    input  logic [NRET*5-1:0]         rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]      rvfi_rd_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ORDER_W-1:0]        out_order,
    output logic [31:0]               out_inst,
    output logic [XLEN-1:0]           out_pc_rdata,
    output logic [XLEN-1:0]           out_pc_wdata,
    output logic [4:0]                out_rd_addr,
    output logic [XLEN-1:0]           out_rd_wdata,
    output logic                      out_halt,
    output logic                      halted,
    output logic [15:0]               errcode,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NRET > 1) ? $clog2(NRET) : 1;

    // Bundle storage
    logic [NRET-1:0]         mem_commit   [DEPTH];
    logic [NRET-1:0]         mem_halt     [DEPTH];
    logic [NRET*ORDER_W-1:0] mem_order    [DEPTH];
    logic [NRET*32-1:0]      mem_inst     [DEPTH];
    logic [NRET*XLEN-1:0]    mem_pc_rdata [DEPTH];
    logic [NRET*XLEN-1:0]    mem_pc_wdata [DEPTH];
    logic [NRET*5-1:0]       mem_rd_addr  [DEPTH];
    logic [NRET*XLEN-1:0]    mem_rd_wdata [DEPTH];

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    // Lowest channel of the head bundle not yet emitted
    logic [CW-1:0]      slot_idx;
    logic [ORDER_W-1:0] exp_order;
    logic               pc_known;
    logic [XLEN-1:0]    last_pc;
    logic               halted_q;
    logic [4:0]         err_q;

    logic [NRET-1:0]    head_commit;
    logic [NRET-1:0]    head_halt;
    logic [CW-1:0]      cur_ch;
    logic               more_after;
    logic               halt_before;

    logic [ORDER_W-1:0] sel_order;
    logic [31:0]        sel_inst;
    logic [XLEN-1:0]    sel_pc_rdata;
    logic [XLEN-1:0]    sel_pc_wdata;
    logic [4:0]         sel_rd_addr;
    logic [XLEN-1:0]    sel_rd_wdata;
    logic               sel_halt;

    logic push;
    logic full;
    logic xfer;
    logic pop;
    logic push_ok;
    logic overflow;

    assign head_commit = mem_commit[rd_ptr];
    assign head_halt   = mem_halt[rd_ptr];

    // Locate the current slot, whether any committed slot follows it, and
    // whether an earlier committed slot of this bundle already carried halt.
    always_comb begin
        logic found;
        found       = 1'b0;
        cur_ch      = '0;
        more_after  = 1'b0;
        halt_before = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (!found && head_commit[i] && (CW'(i) >= slot_idx)) begin
                cur_ch = CW'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NRET; i++) begin
            if (head_commit[i] && (CW'(i) > cur_ch))
                more_after = 1'b1;
            if (head_commit[i] && head_halt[i] && (CW'(i) < cur_ch))
                halt_before = 1'b1;
        end
    end

    always_comb begin
        sel_order    = '0;
        sel_inst     = '0;
        sel_pc_rdata = '0;
        sel_pc_wdata = '0;
        sel_rd_addr  = '0;
        sel_rd_wdata = '0;
        sel_halt     = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (CW'(i) == cur_ch) begin
                sel_order    = mem_order[rd_ptr][i*ORDER_W +: ORDER_W];
                sel_inst     = mem_inst[rd_ptr][i*32 +: 32];
                sel_pc_rdata = mem_pc_rdata[rd_ptr][i*XLEN +: XLEN];
                sel_pc_wdata = mem_pc_wdata[rd_ptr][i*XLEN +: XLEN];
                sel_rd_addr  = mem_rd_addr[rd_ptr][i*5 +: 5];
                sel_rd_wdata = mem_rd_wdata[rd_ptr][i*XLEN +: XLEN];
                sel_halt     = head_halt[i];
            end
        end
    end

    assign out_valid = (count != '0);
    assign push      = |rvfi_commit;
    assign full      = (count == (AW+1)'(DEPTH));
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && !more_after;
    // A pop in the same cycle frees the slot the new bundle lands in.
    assign push_ok   = !rst && push && (!full || pop);
    assign overflow  = push && full && !pop;

    assign out_order    = out_valid ? sel_order    : '0;
    assign out_inst     = out_valid ? sel_inst     : '0;
    assign out_pc_rdata = out_valid ? sel_pc_rdata : '0;
    assign out_pc_wdata = out_valid ? sel_pc_wdata : '0;
    assign out_rd_addr  = out_valid ? sel_rd_addr  : '0;
    assign out_rd_wdata = out_valid ? sel_rd_wdata : '0;
    assign out_halt     = out_valid ? sel_halt     : 1'b0;
    assign halted       = halted_q;
    assign errcode      = {11'b0, err_q};
    assign fifo_level   = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_commit[wr_ptr]   <= rvfi_commit;
            mem_halt[wr_ptr]     <= rvfi_halt;
            mem_order[wr_ptr]    <= rvfi_order;
            mem_inst[wr_ptr]     <= rvfi_inst;
            mem_pc_rdata[wr_ptr] <= rvfi_pc_rdata;
            mem_pc_wdata[wr_ptr] <= rvfi_pc_wdata;
            mem_rd_addr[wr_ptr]  <= rvfi_rd_addr;
            mem_rd_wdata[wr_ptr] <= rvfi_rd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            slot_idx  <= '0;
            exp_order <= '0;
            pc_known  <= 1'b0;
            last_pc   <= '0;
            halted_q  <= 1'b0;
            err_q     <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (xfer) begin
                slot_idx  <= pop ? '0 : cur_ch + CW'(1);
                exp_order <= sel_order + ORDER_W'(1);
                last_pc   <= sel_pc_wdata;
                pc_known  <= 1'b1;
                if (sel_halt)
                    halted_q <= 1'b1;
                if (sel_order != exp_order)
                    err_q[0] <= 1'b1;
                if (pc_known && (sel_pc_rdata != last_pc))
                    err_q[1] <= 1'b1;
                if (halted_q)
                    err_q[2] <= 1'b1;
                if (halt_before)
                    err_q[4] <= 1'b1;
            end

            if (overflow)
                err_q[3] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
module tb_rvfi_commit_serializer;

    localparam int NRET    = 4;
    localparam int XLEN    = 32;
    localparam int ORDER_W = 64;
    localparam int DEPTH   = 8;
    localparam int VW      = 1 + 64 + 32 + 32 + 32 + 5 + 32 + 1 + 1 + 16 + 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NRET-1:0]         rvfi_commit;
    logic [NRET-1:0]         rvfi_halt;
    logic [NRET*ORDER_W-1:0] rvfi_order;
    logic [NRET*32-1:0]      rvfi_inst;
    logic [NRET*XLEN-1:0]    rvfi_pc_rdata;
    logic [NRET*XLEN-1:0]    rvfi_pc_wdata;
    logic [NRET*5-1:0]       rvfi_rd_addr;
    logic [NRET*XLEN-1:0]    rvfi_rd_wdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [ORDER_W-1:0]      out_order;
    logic [31:0]             out_inst;
    logic [XLEN-1:0]         out_pc_rdata;
    logic [XLEN-1:0]         out_pc_wdata;
    logic [4:0]              out_rd_addr;
    logic [XLEN-1:0]         out_rd_wdata;
    logic                    out_halt;
    logic                    halted;
    logic [15:0]             errcode;
    logic [3:0]              fifo_level;

    int checks = 0;
    int errors = 0;

    rvfi_commit_serializer #(
        .NRET(NRET), .XLEN(XLEN), .ORDER_W(ORDER_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rvfi_commit(rvfi_commit), .rvfi_halt(rvfi_halt),
        .rvfi_order(rvfi_order), .rvfi_inst(rvfi_inst),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_order(out_order), .out_inst(out_inst),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .out_halt(out_halt), .halted(halted),
        .errcode(errcode), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: stream of slots ----------------
    typedef struct {
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc_r;
        logic [31:0] pc_w;
        logic [4:0]  rd;
        logic [31:0] rd_w;
        logic        halt;
    } slot_t;

    slot_t       slot_q[$];   // all buffered committed slots, program order
    int          bcnt_q[$];   // slots remaining per buffered bundle
    logic [15:0] m_err;
    logic        m_halted;
    logic [63:0] m_exp_order;
    logic        m_pc_known;
    logic [31:0] m_last_pc;
    logic        m_halt_seen; // halt already emitted from the head bundle

    logic [63:0] g_ord;
    logic [31:0] g_pc;

    task automatic model_clear();
        slot_q.delete();
        bcnt_q.delete();
        m_err = '0; m_halted = 0; m_exp_order = '0;
        m_pc_known = 0; m_last_pc = '0; m_halt_seen = 0;
    endtask

    task automatic model_step();
        slot_t s;
        if (rst) begin
            model_clear();
            return;
        end
        if (bcnt_q.size() > 0 && out_ready) begin
            s = slot_q.pop_front();
            if (s.order != m_exp_order) m_err[0] = 1'b1;
            if (m_pc_known && s.pc_r != m_last_pc) m_err[1] = 1'b1;
            if (m_halted) m_err[2] = 1'b1;
            if (m_halt_seen) m_err[4] = 1'b1;
            if (s.halt) begin m_halted = 1'b1; m_halt_seen = 1'b1; end
            m_exp_order = s.order + 64'd1;
            m_last_pc   = s.pc_w;
            m_pc_known  = 1'b1;
            bcnt_q[0] = bcnt_q[0] - 1;
            if (bcnt_q[0] == 0) begin
                void'(bcnt_q.pop_front());
                m_halt_seen = 1'b0;
            end
        end
        if (rvfi_commit != '0) begin
            if (bcnt_q.size() >= DEPTH) begin
                m_err[3] = 1'b1;
            end else begin
                int n = 0;
                for (int i = 0; i < NRET; i++) begin
                    if (rvfi_commit[i]) begin
                        s.order = rvfi_order[i*64 +: 64];
                        s.inst  = rvfi_inst[i*32 +: 32];
                        s.pc_r  = rvfi_pc_rdata[i*32 +: 32];
                        s.pc_w  = rvfi_pc_wdata[i*32 +: 32];
                        s.rd    = rvfi_rd_addr[i*5 +: 5];
                        s.rd_w  = rvfi_rd_wdata[i*32 +: 32];
                        s.halt  = rvfi_halt[i];
                        slot_q.push_back(s);
                        n++;
                    end
                end
                bcnt_q.push_back(n);
            end
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        slot_t s;
        if (bcnt_q.size() == 0)
            return {1'b0, 64'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0,
                    m_halted, m_err, 4'd0};
        s = slot_q[0];
        return {1'b1, s.order, s.inst, s.pc_r, s.pc_w, s.rd, s.rd_w, s.halt,
                m_halted, m_err, 4'(bcnt_q.size())};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {out_valid, out_order, out_inst, out_pc_rdata, out_pc_wdata,
                out_rd_addr, out_rd_wdata, out_halt, halted, errcode, fifo_level};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Committed channels get consecutive orders and contiguous PCs starting
    // at ord0/pc0; idle channels carry junk.
    task automatic set_bundle(input logic [NRET-1:0] c, input logic [NRET-1:0] h,
                              input logic [63:0] ord0, input logic [31:0] pc0);
        logic [63:0] o = ord0;
        logic [31:0] p = pc0;
        rvfi_commit = c;
        rvfi_halt   = h;
        for (int i = 0; i < NRET; i++) begin
            rvfi_inst[i*32 +: 32]     = $urandom;
            rvfi_rd_addr[i*5 +: 5]    = 5'($urandom);
            rvfi_rd_wdata[i*32 +: 32] = $urandom;
            if (c[i]) begin
                rvfi_order[i*64 +: 64]    = o;
                rvfi_pc_rdata[i*32 +: 32] = p;
                rvfi_pc_wdata[i*32 +: 32] = p + 32'd4;
                o = o + 64'd1;
                p = p + 32'd4;
            end else begin
                rvfi_order[i*64 +: 64]    = {$urandom, $urandom};
                rvfi_pc_rdata[i*32 +: 32] = $urandom;
                rvfi_pc_wdata[i*32 +: 32] = $urandom;
            end
        end
        g_ord = o;
        g_pc  = p;
    endtask

    task automatic clear_bundle();
        rvfi_commit = '0;
        rvfi_halt   = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_bundle(4'b1111, 4'b0001, 64'd9, 32'h40);
        out_ready = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        clear_bundle();
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", dut_vec());
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h required %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_full_bundle();
        apply_reset();
        out_ready = 1'b1;
        set_bundle(4'b1111, 4'b0000, 64'd0, 32'h60);
        cycle();
        clear_bundle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_order !== 64'(k) || out_pc_rdata !== 32'h60 + 32'(4*k)) begin
                errors++;
                $display("FAIL full_slot%0d: got v=%b ord=%0d pc=%h required v=1 ord=%0d pc=%h",
                         k, out_valid, out_order, out_pc_rdata, k, 32'h60 + 32'(4*k));
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL full_model%0d: got %h required %h", k, dut_vec(), model_vec());
            end
            cycle();
        end
        checks++;
        if (out_valid !== 1'b0 || errcode !== 16'h0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL full_end: got v=%b err=%h lvl=%0d required v=0 err=0 lvl=0",
                     out_valid, errcode, fifo_level);
        end
    endtask

    task automatic test_sparse();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
        apply_reset();
        out_ready = 1'b1;
        set_bundle(4'b1010, 4'b0000, 64'd0, 32'h100);
        cycle();
        set_bundle(4'b0001, 4'b0000, 64'd2, 32'h108);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_order !== 64'(k) || out_pc_rdata !== exp_pc[k]) begin
                errors++;
                $display("FAIL sparse_slot%0d: got v=%b ord=%0d pc=%h required v=1 ord=%0d pc=%h",
                         k, out_valid, out_order, out_pc_rdata, k, exp_pc[k]);
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL sparse_model%0d: got %h required %h", k, dut_vec(), model_vec());
            end
            cycle();
            clear_bundle();
        end
        checks++;
        if (errcode !== 16'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sparse_end: got err=%h v=%b required err=0 v=0", errcode, out_valid);
        end
    endtask

    task automatic test_order_pc_errors();
        apply_reset();
        out_ready = 1'b1;
        set_bundle(4'b0011, 4'b0000, 64'd0, 32'h200);
        cycle();
        set_bundle(4'b0001, 4'b0000, 64'd3, 32'h208);
        cycle();
        clear_bundle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL gap_model%0d: got %h required %h", k, dut_vec(), model_vec());
            end
            cycle();
        end
        checks++;
        if (errcode !== 16'h0001) begin
            errors++;
            $display("FAIL order_gap: got err=%h required 0001", errcode);
        end
        set_bundle(4'b0001, 4'b0000, 64'd4, 32'h300);
        cycle();
        clear_bundle();
        cycle();
        checks++;
        if (errcode !== 16'h0003 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pc_jump: got err=%h v=%b required 0003 v=0", errcode, out_valid);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        apply_reset();
        out_ready = 1'b0;
        g_ord = 64'd0;
        g_pc  = 32'h1000;
        for (int b = 0; b < 9; b++) begin
            set_bundle(4'b1111, 4'b0000, g_ord, g_pc);
            cycle();
        end
        clear_bundle();
        checks++;
        if (fifo_level !== 4'd8 || errcode !== 16'h0008) begin
            errors++;
            $display("FAIL overflow_fill: got lvl=%0d err=%h required 8 0008", fifo_level, errcode);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && out_valid; c++) begin
            n++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL overflow_model%0d: got %h required %h", c, dut_vec(), model_vec());
            end
            cycle();
        end
        checks++;
        if (n != 32 || errcode !== 16'h0008 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL overflow_drain: got slots=%0d err=%h lvl=%0d required 32 0008 0",
                     n, errcode, fifo_level);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        out_ready = 1'b1;
        set_bundle(4'b0101, 4'b0001, 64'd0, 32'h400);
        cycle();
        clear_bundle();
        checks++;
        if (out_halt !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_head: got out_halt=%b halted=%b required 1 0", out_halt, halted);
        end
        cycle();
        checks++;
        if (halted !== 1'b1 || errcode !== 16'h0000 || out_order !== 64'd1) begin
            errors++;
            $display("FAIL halt_set: got halted=%b err=%h ord=%0d required 1 0000 1",
                     halted, errcode, out_order);
        end
        cycle();
        checks++;
        if (errcode !== 16'h0014 || halted !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_after: got err=%h halted=%b v=%b required 0014 1 0",
                     errcode, halted, out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        out_ready = 1'b1;
        set_bundle(4'b1111, 4'b0000, 64'd5, 32'h500);
        cycle();
        clear_bundle();
        cycle();
        cycle();
        checks++;
        if (errcode !== 16'h0001 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL middrain_pre: got err=%h lvl=%0d required 0001 1", errcode, fifo_level);
        end
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || errcode !== 16'h0 || halted !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL middrain_reset: got v=%b err=%h halted=%b lvl=%0d required 0 0 0 0",
                     out_valid, errcode, halted, fifo_level);
        end
        set_bundle(4'b1111, 4'b0000, 64'd0, 32'h600);
        cycle();
        clear_bundle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_order !== 64'(k) || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL middrain_fresh%0d: got %h required %h", k, dut_vec(), model_vec());
            end
            cycle();
        end
        checks++;
        if (errcode !== 16'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL middrain_end: got err=%h v=%b required 0 0", errcode, out_valid);
        end
    endtask

    task automatic test_random();
        apply_reset();
        g_ord = 64'd0;
        g_pc  = 32'h8000;
        for (int c = 0; c < 600; c++) begin
            logic [63:0] o;
            logic [31:0] p;
            rst = (c % 150 == 149);
            if (rst) begin g_ord = 64'd0; g_pc = 32'h8000; end
            o = ($urandom_range(0, 19) == 0) ? g_ord + 64'($urandom_range(2, 5)) : g_ord;
            p = ($urandom_range(0, 19) == 0) ? g_pc + 32'h40 : g_pc;
            set_bundle(($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom),
                       ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'b0000, o, p);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random_c%0d: got %h required %h", c, dut_vec(), model_vec());
            end
        end
        rst = 1'b0;
        clear_bundle();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        g_ord = '0;
        g_pc  = '0;
        rvfi_order = '0; rvfi_inst = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
        rvfi_rd_addr = '0; rvfi_rd_wdata = '0;
        clear_bundle();
        model_clear();
        @(negedge clk);
        test_reset();
        test_full_bundle();
        test_sparse();
        test_order_pc_errors();
        test_overflow();
        test_halt();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_commit_serializer.md
Name: rvfi_commit_serializer

Overview:
- Verification-side monitor block. Samples an NRET-wide RISC-V Formal Interface retire bundle every cycle and buffers each bundle that carries at least one commit in a packet FIFO.
- Emits committed instructions one per handshake, in program order, on a single-channel output stream for the golden-model comparator.
- Checks order sequencing, PC continuity, commit-after-halt and FIFO overflow, and reports violations as sticky error bits.

Parameters:
- NRET, 4, number of retire channels per cycle (1..8)
- XLEN, 32, data and PC width
- ORDER_W, 64, width of the per-channel order field
- DEPTH, 8, packet FIFO depth in bundles (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rvfi_commit  in  NRET  per-channel commit strobe
- rvfi_halt  in  NRET  per-channel halt flag
- rvfi_order  in  NRET*ORDER_W  per-channel retire order; channel i occupies bits [i*ORDER_W +: ORDER_W]
- rvfi_inst  in  NRET*32  instruction word
- rvfi_pc_rdata  in  NRET*XLEN  PC of the instruction
- rvfi_pc_wdata  in  NRET*XLEN  next PC
- rvfi_rd_addr  in  NRET*5  destination register
- rvfi_rd_wdata  in  NRET*XLEN  destination write data
- out_valid  out  1  serialized slot available
- out_ready  in  1  consumer accepts the slot
- out_order  out  ORDER_W  order of the emitted slot
- out_inst  out  32  instruction word
- out_pc_rdata  out  XLEN  PC
- out_pc_wdata  out  XLEN  next PC
- out_rd_addr  out  5  destination register
- out_rd_wdata  out  XLEN  write data
- out_halt  out  1  emitted slot carries halt
- halted  out  1  a halt slot has been emitted
- errcode  out  16  sticky error bits
- fifo_level  out  $clog2(DEPTH)+1  bundles currently buffered

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied; head slot index cleared.
  - expected_order=0; pc_known=0.
  - Outputs: out_valid=0, halted=0, errcode=0, fifo_level=0. All out_* data outputs drive 0 while out_valid=0.
  - Reset wins over every simultaneous event and aborts any partially drained bundle.
- Capture:
  - Each cycle with |rvfi_commit=1, the whole bundle is written to the FIFO. Bundles with no commit are ignored.
  - The block never backpressures the DUT.
  - If the FIFO is full and no pop happens in the same cycle, the bundle is dropped and errcode[3] is set.
  - Push and pop in the same cycle when full: the pop frees the slot and the push is accepted, with no error.
- Serialize:
  - The head bundle is drained in ascending channel index, skipping channels whose commit bit is 0.
  - out_valid=1 whenever the FIFO is non-empty; out_* reflect the current head slot combinationally from FIFO storage.
  - A slot transfers when out_valid && out_ready.
  - On transfer of the last committed slot of the head bundle, the bundle is popped and the slot index resets, so the next bundle is presented in the following cycle.
  - Throughput: one slot per cycle when out_ready is held high. A full NRET bundle drains in NRET cycles.
- Checks, evaluated on each transfer:
  - errcode[0] (order): out_order != expected_order. After every transfer, expected_order = out_order+1, computed modulo 2^ORDER_W so wrap-around is legal.
  - errcode[1] (PC): pc_known && out_pc_rdata != last_pc_wdata. After each transfer, last_pc_wdata is updated and pc_known is set.
  - errcode[2] (commit-after-halt): a transfer occurs while halted=1.
  - errcode[4] (halt order): a halt slot is followed by a committed slot of a higher channel in the same bundle. This is flagged when that slot transfers.
  - errcode[15:5] reserved, held at 0.
- Halt:
  - halted is set the cycle after a transfer with out_halt=1 and stays set until rst.
  - Draining continues after halt so that errcode[2] can fire.
- errcode bits are sticky until rst. Multiple bits may set in the same cycle.
- fifo_level reflects the post-edge count: increments on push, decrements on pop, unchanged on push+pop.

Test Plan:
- NRET=4, one bundle with commit=4'b1111, orders 0..3, contiguous PCs 0x60..0x6c, out_ready=1 -> 4 transfers on consecutive cycles, orders 0,1,2,3, errcode=0, fifo_level returns to 0.
- Sparse bundle commit=4'b1010 (orders 0,1), then commit=4'b0001 (order 2) -> channels 1, 3, 0 emitted in that sequence, errcode=0.
- Order gap: orders 0,1 then next bundle order 3 -> errcode[0]=1 on the third transfer and remains set; PC mismatch (pc_rdata != prior pc_wdata) -> errcode[1]=1.
- out_ready=0 while 9 full bundles arrive with DEPTH=8 -> fifo_level=8, errcode[3]=1; then out_ready=1 drains exactly 32 slots with no further errors.
- Halt on channel 0 with channel 2 also committed -> halted=1 after the first transfer, errcode[4] and errcode[2] set when channel 2 transfers.
- Assert rst mid-drain of a 4-slot bundle -> next cycle out_valid=0, errcode=0, halted=0, and a fresh bundle starting at order 0 passes clean.
